// File: rtl/dyt_load_store_unit_if.sv
// CPU <-> load/store unit request/grant bundle.
interface dyt_load_store_unit_if;
  logic [31:0] mem_address;
  logic [31:0] mem_w_data;
  logic        mem_d_ren;
  logic        mem_i_ren;
  logic        mem_wen;
  logic [1:0]  mem_w_type;
  logic [31:0] mem_r_data;
  logic        mem_d_gnt;
  logic        mem_i_gnt;

  // CPU side
  modport master (
    output mem_address, mem_w_data, mem_d_ren, mem_i_ren, mem_wen, mem_w_type,
    input  mem_r_data, mem_d_gnt, mem_i_gnt
  );

  // Responder side
  modport slave (
    input  mem_address, mem_w_data, mem_d_ren, mem_i_ren, mem_wen, mem_w_type,
    output mem_r_data, mem_d_gnt, mem_i_gnt
  );

  // Load/store unit view (same direction as slave)
  modport lsu (
    input  mem_address, mem_w_data, mem_d_ren, mem_i_ren, mem_wen, mem_w_type,
    output mem_r_data, mem_d_gnt, mem_i_gnt
  );
endinterface

// File: rtl/dyt_load_store_unit.sv
// Arbitrates instruction fetch and data access onto one variable-latency SRAM port.
//
// state  | meaning
// IDLE   | waiting for a request; picks a winner and latches its fields
// ACCESS | SRAM strobes held until sram_ready or timeout
// GRANT  | one-cycle grant pulse to the CPU
module dyt_load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          DATA_FIRST     = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  dyt_load_store_unit_if.lsu    lsu_if,
  output logic                  mem_err,
  output logic [31:0]           sram_addr,
  output logic [31:0]           sram_wdata,
  output logic [3:0]            sram_ben,
  output logic                  sram_ren,
  output logic                  sram_wen,
  input  logic [31:0]           sram_rdata,
  input  logic                  sram_ready
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_GRANT  = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        instr_q, instr_d;
  logic [31:0] r_data_q, r_data_d;
  logic        d_gnt_q, d_gnt_d;
  logic        i_gnt_q, i_gnt_d;
  logic        err_q, err_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  ben_q, ben_d;
  logic        ren_q, ren_d;
  logic        wen_q, wen_d;

  logic        data_req, pick_data, pick_instr, sel_write;
  logic        is_byte, is_half, misaligned, timed_out;
  logic [3:0]  ben_sel;
  logic [31:0] wdata_sel;

  // Request arbitration and width decode of the incoming CPU fields.
  always_comb begin
    data_req   = lsu_if.mem_d_ren | lsu_if.mem_wen;
    pick_data  = data_req & (DATA_FIRST | ~lsu_if.mem_i_ren);
    pick_instr = lsu_if.mem_i_ren & ~pick_data;
    sel_write  = pick_data & lsu_if.mem_wen;
    is_byte    = pick_data & (lsu_if.mem_w_type == 2'b00);
    is_half    = pick_data & (lsu_if.mem_w_type == 2'b01);
    if (is_byte) begin
      misaligned = 1'b0;
      ben_sel    = 4'b0001 << lsu_if.mem_address[1:0];
      wdata_sel  = {4{lsu_if.mem_w_data[7:0]}};
    end else if (is_half) begin
      misaligned = lsu_if.mem_address[0];
      ben_sel    = lsu_if.mem_address[1] ? 4'b1100 : 4'b0011;
      wdata_sel  = {2{lsu_if.mem_w_data[15:0]}};
    end else begin
      misaligned = (lsu_if.mem_address[1:0] != 2'b00);
      ben_sel    = 4'b1111;
      wdata_sel  = lsu_if.mem_w_data;
    end
  end

  assign timed_out = (cnt_q == CNT_LAST);

  // State and registered outputs; reset abandons any in-flight access.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      instr_q  <= 1'b0;
      r_data_q <= '0;
      d_gnt_q  <= 1'b0;
      i_gnt_q  <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ben_q    <= '0;
      ren_q    <= 1'b0;
      wen_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      instr_q  <= instr_d;
      r_data_q <= r_data_d;
      d_gnt_q  <= d_gnt_d;
      i_gnt_q  <= i_gnt_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ben_q    <= ben_d;
      ren_q    <= ren_d;
      wen_q    <= wen_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (pick_data | pick_instr) state_d = misaligned ? S_GRANT : S_ACCESS;
      S_ACCESS: if (sram_ready | timed_out) state_d = S_GRANT;
      S_GRANT:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; a grant is one cycle ahead of the GRANT state.
  always_comb begin
    cnt_d    = cnt_q;
    instr_d  = instr_q;
    r_data_d = r_data_q;
    d_gnt_d  = 1'b0;
    i_gnt_d  = 1'b0;
    err_d    = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ben_d    = ben_q;
    ren_d    = ren_q;
    wen_d    = wen_q;
    case (state_q)
      S_IDLE: begin
        if (pick_data | pick_instr) begin
          instr_d = pick_instr;
          cnt_d   = '0;
          addr_d  = {lsu_if.mem_address[31:2], 2'b00};
          ben_d   = ben_sel;
          wdata_d = wdata_sel;
          if (misaligned) begin
            d_gnt_d  = pick_data;
            i_gnt_d  = pick_instr;
            err_d    = 1'b1;
            r_data_d = '0;
          end else begin
            ren_d = ~sel_write;
            wen_d = sel_write;
          end
        end
      end
      S_ACCESS: begin
        if (sram_ready | timed_out) begin
          ren_d    = 1'b0;
          wen_d    = 1'b0;
          d_gnt_d  = ~instr_q;
          i_gnt_d  = instr_q;
          err_d    = ~sram_ready;
          r_data_d = (sram_ready & ren_q) ? sram_rdata : 32'h0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  assign lsu_if.mem_r_data = r_data_q;
  assign lsu_if.mem_d_gnt  = d_gnt_q;
  assign lsu_if.mem_i_gnt  = i_gnt_q;
  assign mem_err           = err_q;
  assign sram_addr         = addr_q;
  assign sram_wdata        = wdata_q;
  assign sram_ben          = ben_q;
  assign sram_ren          = ren_q;
  assign sram_wen          = wen_q;

endmodule

// File: tb/tb_dyt_load_store_unit.sv
// Directed and randomized bench for the load/store unit.
module tb_dyt_load_store_unit;
  localparam int TMO = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        mem_err;
  logic [31:0] sram_addr, sram_wdata, sram_rdata;
  logic [3:0]  sram_ben;
  logic        sram_ren, sram_wen, sram_ready;

  int errors = 0;
  int checks = 0;

  dyt_load_store_unit_if bus ();

  dyt_load_store_unit #(.TIMEOUT_CYCLES(TMO), .DATA_FIRST(1'b1)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .lsu_if     (bus),
    .mem_err    (mem_err),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_ben   (sram_ben),
    .sram_ren   (sram_ren),
    .sram_wen   (sram_wen),
    .sram_rdata (sram_rdata),
    .sram_ready (sram_ready)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drop_req;
    bus.mem_d_ren = 1'b0;
    bus.mem_i_ren = 1'b0;
    bus.mem_wen   = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_dgnt"}, {31'd0, bus.mem_d_gnt}, 32'd0);
    check({tag, "_ignt"}, {31'd0, bus.mem_i_gnt}, 32'd0);
    check({tag, "_ren"},  {31'd0, sram_ren}, 32'd0);
    check({tag, "_wen"},  {31'd0, sram_wen}, 32'd0);
  endtask

  // Access width in bytes from the request kind and type code.
  function automatic int size_of(input bit instr, input logic [1:0] wt);
    if (instr) return 4;
    if (wt == 2'b00) return 1;
    if (wt == 2'b01) return 2;
    return 4;
  endfunction

  // One access: request in cycle 0, SRAM ready after 'waits' stall cycles.
  task automatic do_access(input string tag, input bit instr, input bit wr,
                           input logic [1:0] wt, input logic [31:0] a,
                           input logic [31:0] wd, input int waits,
                           input logic [31:0] rd);
    int          sz, last, c;
    bit          misal, tmo, is_wr;
    logic [3:0]  eben;
    logic [31:0] ewd, eaddr;
    sz    = size_of(instr, wt);
    is_wr = wr && !instr;
    misal = (a % sz) != 0;
    eaddr = a - (a % 4);
    eben  = 4'(((1 << sz) - 1) << ((a - (a % sz)) % 4));
    if (sz == 1)      ewd = wd[7:0] * 32'h0101_0101;
    else if (sz == 2) ewd = wd[15:0] * 32'h0001_0001;
    else              ewd = wd;
    tmo  = (waits + 1) > TMO;
    last = tmo ? TMO : waits + 1;

    bus.mem_i_ren   = instr;
    bus.mem_d_ren   = !instr && !wr;
    bus.mem_wen     = is_wr;
    bus.mem_address = a;
    bus.mem_w_data  = wd;
    bus.mem_w_type  = wt;

    if (!misal) begin
      for (c = 1; c <= last; c++) begin
        step();
        sram_ready = 1'b0;
        check({tag, "_ren"},  {31'd0, sram_ren}, {31'd0, !is_wr});
        check({tag, "_wen"},  {31'd0, sram_wen}, {31'd0, is_wr});
        check({tag, "_addr"}, sram_addr, eaddr);
        check({tag, "_ben"},  {28'd0, sram_ben}, {28'd0, eben});
        if (is_wr) check({tag, "_wdata"}, sram_wdata, ewd);
        check({tag, "_early_gnt"}, {31'd0, bus.mem_d_gnt | bus.mem_i_gnt}, 32'd0);
        if (c == waits + 1) begin
          sram_ready = 1'b1;
          sram_rdata = rd;
        end
      end
    end
    step();
    sram_ready = 1'b0;
    sram_rdata = $urandom;
    check({tag, "_dgnt"}, {31'd0, bus.mem_d_gnt}, {31'd0, !instr});
    check({tag, "_ignt"}, {31'd0, bus.mem_i_gnt}, {31'd0, instr});
    check({tag, "_err"},  {31'd0, mem_err}, {31'd0, misal || tmo});
    check({tag, "_rdata"}, bus.mem_r_data, (!misal && !tmo && !is_wr) ? rd : 32'h0);
    check({tag, "_strobe_off"}, {31'd0, sram_ren | sram_wen}, 32'd0);
    drop_req();
    step();
    check_quiet({tag, "_after"});
  endtask

  initial begin
    drop_req();
    bus.mem_address = '0;
    bus.mem_w_data  = '0;
    bus.mem_w_type  = 2'b10;
    sram_ready = 1'b0;
    sram_rdata = '0;
    RST = 1'b1;
    step();
    step();
    check("rst_rdata", bus.mem_r_data, 32'h0);
    check("rst_err",   {31'd0, mem_err}, 32'd0);
    check("rst_addr",  sram_addr, 32'h0);
    check("rst_wdata", sram_wdata, 32'h0);
    check("rst_ben",   {28'd0, sram_ben}, 32'd0);
    check_quiet("rst");
    RST = 1'b0;
    step();

    do_access("word_load", 1'b0, 1'b0, 2'b10, 32'h100, 32'h0, 0, 32'hDEAD_BEEF);
    do_access("byte_store", 1'b0, 1'b1, 2'b00, 32'h203, 32'h0000_00A5, 3, 32'h0);
    do_access("mis_half", 1'b0, 1'b0, 2'b01, 32'h101, 32'h0, 0, 32'h1234_5678);
    do_access("mis_fetch", 1'b1, 1'b0, 2'b10, 32'h42, 32'h0, 0, 32'h1234_5678);
    do_access("timeout", 1'b0, 1'b0, 2'b10, 32'h300, 32'h0, 20, 32'h5555_AAAA);
    do_access("half_hi", 1'b0, 1'b1, 2'b01, 32'h402, 32'hCAFE_1234, 1, 32'h0);
    do_access("type11", 1'b0, 1'b1, 2'b11, 32'h404, 32'h8765_4321, 0, 32'h0);

    // Data and fetch together: data first, then the fetch after the grant.
    bus.mem_d_ren   = 1'b1;
    bus.mem_i_ren   = 1'b1;
    bus.mem_address = 32'h80;
    step();
    check("both_c1_ren", {31'd0, sram_ren}, 32'd1);
    check("both_c1_addr", sram_addr, 32'h80);
    sram_ready = 1'b1;
    sram_rdata = 32'h1111_2222;
    step();
    sram_ready = 1'b0;
    check("both_c2_dgnt", {31'd0, bus.mem_d_gnt}, 32'd1);
    check("both_c2_ignt", {31'd0, bus.mem_i_gnt}, 32'd0);
    check("both_c2_rdata", bus.mem_r_data, 32'h1111_2222);
    bus.mem_d_ren   = 1'b0;
    bus.mem_address = 32'h40;
    step();
    check_quiet("both_c3");
    step();
    check("both_c4_ren", {31'd0, sram_ren}, 32'd1);
    check("both_c4_addr", sram_addr, 32'h40);
    sram_ready = 1'b1;
    sram_rdata = 32'h0000_0013;
    step();
    sram_ready = 1'b0;
    check("both_c5_ignt", {31'd0, bus.mem_i_gnt}, 32'd1);
    check("both_c5_dgnt", {31'd0, bus.mem_d_gnt}, 32'd0);
    check("both_c5_rdata", bus.mem_r_data, 32'h0000_0013);
    drop_req();
    step();
    check_quiet("both_c6");

    // Write and read asserted together: the write wins.
    bus.mem_d_ren   = 1'b1;
    bus.mem_wen     = 1'b1;
    bus.mem_w_type  = 2'b10;
    bus.mem_address = 32'h500;
    step();
    check("wr_wins_wen", {31'd0, sram_wen}, 32'd1);
    check("wr_wins_ren", {31'd0, sram_ren}, 32'd0);
    sram_ready = 1'b1;
    step();
    sram_ready = 1'b0;
    check("wr_wins_gnt", {31'd0, bus.mem_d_gnt}, 32'd1);
    drop_req();
    step();

    // Reset in the middle of a long write abandons it.
    bus.mem_wen     = 1'b1;
    bus.mem_w_type  = 2'b10;
    bus.mem_address = 32'h600;
    bus.mem_w_data  = 32'hFEED_F00D;
    step();
    check("rst_mid_c1_wen", {31'd0, sram_wen}, 32'd1);
    step();
    check("rst_mid_c2_wen", {31'd0, sram_wen}, 32'd1);
    RST = 1'b1;
    step();
    check_quiet("rst_mid_c3");
    check("rst_mid_c3_addr", sram_addr, 32'h0);
    RST = 1'b0;
    drop_req();
    step();
    check_quiet("rst_mid_c4");
    do_access("post_rst_load", 1'b0, 1'b0, 2'b10, 32'h700, 32'h0, 2, 32'h0BAD_CAFE);

    // Randomized accesses against the width/alignment model.
    for (int n = 0; n < 40; n++) begin
      do_access("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)), $urandom, $urandom,
                $urandom_range(0, 5), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dyt_load_store_unit.md
# dyt_load_store_unit

The load store unit arbitrates the CPU's instruction-fetch and data requests onto one single-ported, variable-latency SRAM port. It sits directly downstream of the CPU on the `dyt_load_store_unit_if` `lsu` modport and directly upstream of the SRAM.
- Byte and halfword stores become SRAM byte enables.
- Misaligned accesses and SRAM timeouts are flagged to the CPU.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum cycles spent waiting on `sram_ready` before the access is aborted. Range 1..255.
- `DATA_FIRST`, default 1: when both request types are pending in IDLE, 1 serves data first and 0 serves instruction first.

Ports:
- `CLK` input 1: clock; all logic on the rising edge.
- `RST` input 1: reset, synchronous, active-high.
- `lsu_if` modport `lsu`: carries `mem_address`, `mem_w_data`, `mem_d_ren`, `mem_i_ren`, `mem_wen`, `mem_w_type` in, and `mem_r_data`, `mem_d_gnt`, `mem_i_gnt` out.
- `mem_err` output 1: qualifies a grant as misaligned or timed out. Valid only in a grant cycle.
- `sram_addr` output 32: word address. Byte address with bits [1:0] forced to 0.
- `sram_wdata` output 32: store data, replicated across lanes.
- `sram_ben` output 4: byte enables. Bit i enables byte [8i+7:8i].
- `sram_ren` output 1: read strobe, held until `sram_ready`.
- `sram_wen` output 1: write strobe, held until `sram_ready`.
- `sram_rdata` input 32: read data, valid when `sram_ready` is high.
- `sram_ready` input 1: access complete.

## Operation
- `mem_w_type` encoding: BYTE=00, HALF=01, WORD=10. Encoding 11 is treated as WORD.
- Data request = `mem_d_ren | mem_wen`. If both are high, the write wins.
- Instruction fetches are always WORD.
- Byte enables:
  - BYTE: one-hot on `addr[1:0]`.
  - HALF: 0011 if `addr[1]`=0, else 1100.
  - WORD: 1111.
  - Reads also drive the enables for the access width.
- `sram_wdata`:
  - BYTE: `{4{w_data[7:0]}}`.
  - HALF: `{2{w_data[15:0]}}`.
  - WORD: `w_data`.
- `mem_r_data` returns the raw aligned SRAM word. Lane extraction and sign extension are done in the CPU.
- Misaligned access: HALF with `addr[0]`=1, or WORD/fetch with `addr[1:0]`≠0.
  - No SRAM strobe is issued.
  - The grant is given in the next cycle with `mem_err`=1 and `mem_r_data`=0.
- FSM states: IDLE, ACCESS, GRANT.
  - IDLE: when a request is pending, pick one (winner per `DATA_FIRST`) and latch address, data, type, and kind. Go to ACCESS, or to GRANT with error if misaligned.
  - ACCESS: SRAM strobes, address, enables, and data are driven from the latched values. The timeout counter increments each cycle.
    - On `sram_ready`: latch `sram_rdata` (reads only) and go to GRANT.
    - If the counter reaches `TIMEOUT_CYCLES` without `sram_ready`: drop the strobes, set the error, and go to GRANT.
  - GRANT: pulse `mem_d_gnt` or `mem_i_gnt` for exactly one cycle, then go to IDLE. Requests are not sampled in GRANT.
- CPU rule: hold the request and its fields stable until the grant, and deassert in the cycle after the grant. The LSU ignores input changes after latching.
- A request dropped before its grant still completes on the SRAM. The grant pulse is still issued.
- `mem_d_gnt` and `mem_i_gnt` are never high together.

## Timing
- Reset values: `mem_r_data`=0, `mem_d_gnt`=0, `mem_i_gnt`=0, `mem_err`=0, `sram_addr`=0, `sram_wdata`=0, `sram_ben`=0, `sram_ren`=0, `sram_wen`=0. State=IDLE, counter=0.
- All outputs are registered.
- Latency for a request first seen in IDLE at cycle 0:
  - Strobes are high in cycles 1..k, where k is the first cycle with `sram_ready`=1.
  - Grant is in cycle k+1.
  - With a zero-wait SRAM the grant is in cycle 2.
- Misaligned access: grant in cycle 1, with no strobe ever raised.
- Timeout: strobes are high for `TIMEOUT_CYCLES` cycles, then the grant with `mem_err`=1 in the following cycle.
- Back-to-back: the earliest next acceptance is the IDLE cycle after GRANT. The minimum period is 3 cycles per access.
- `RST` mid-access: all outputs return to reset values on the next edge and strobes drop immediately at that edge. The in-flight access is abandoned with no grant.

## Test plan
- Word load, zero-wait SRAM: `d_ren`, addr `0x100`, `sram_rdata`=`0xDEADBEEF` ready in cycle 1 → `sram_addr`=`0x100`, `ben`=1111 in cycle 1; `mem_d_gnt`=1 with `r_data`=`0xDEADBEEF`, `err`=0 in cycle 2 only.
- Byte store: `wen`, BYTE, addr `0x203`, `w_data`=`0x000000A5`, ready after 3 wait cycles → `sram_addr`=`0x200`, `ben`=1000, `wdata`=`0xA5A5A5A5` held 4 cycles; `d_gnt` in cycle 5.
- Simultaneous `i_ren` (addr `0x40`) and `d_ren` (addr `0x80`), `DATA_FIRST`=1, zero-wait → `d_gnt` at cycle 2; fetch to `0x40` issued in cycle 4; `i_gnt` at cycle 5.
- Misaligned: HALF load at `0x101` → no SRAM strobe; `d_gnt`=1 with `err`=1 and `r_data`=0 at cycle 1. Fetch at `0x42` → `i_gnt` with `err`=1 at cycle 1.
- Timeout: `TIMEOUT_CYCLES`=4, `sram_ready` held 0 → `sram_ren` high in cycles 1–4, low in cycle 5; `d_gnt` with `err`=1 in cycle 5.
- Reset mid-access: assert `RST` in cycle 2 of a 5-wait write → strobes 0 from cycle 3; no grant; a fresh load after reset completes normally.
